// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the traffic light controller and its monitor.
//   phase_e      : decoded phase of the two-way intersection
//   CODE_*       : lamp codes {R1,Y1,G1,R2,Y2,G2} for each legal phase
//   is_run()     : true for the five running phases A..AR
//   legal_succ() : true when a phase change follows the signal plan
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_A    = 3'd1,  // G1 / R2
    PH_B    = 3'd2,  // Y1 / R2
    PH_C    = 3'd3,  // R1 / G2
    PH_D    = 3'd4,  // R1 / Y2
    PH_AR   = 3'd5,  // all red
    PH_ILL  = 3'd7
  } phase_e;

  localparam logic [5:0] CODE_A  = 6'b001100;
  localparam logic [5:0] CODE_B  = 6'b010100;
  localparam logic [5:0] CODE_C  = 6'b100001;
  localparam logic [5:0] CODE_D  = 6'b100010;
  localparam logic [5:0] CODE_AR = 6'b100100;

  function automatic logic is_run(input phase_e p);
    return (p == PH_A) || (p == PH_B) || (p == PH_C) ||
           (p == PH_D) || (p == PH_AR);
  endfunction

  // Signal plan: A->B, B->C|AR, C->D, D->A|AR, AR->A|C.
  // From IDLE or ILL any running phase is acceptable.
  function automatic logic legal_succ(input phase_e from_p, input phase_e to_p);
    logic ok;
    case (from_p)
      PH_A:    ok = (to_p == PH_B);
      PH_B:    ok = (to_p == PH_C) || (to_p == PH_AR);
      PH_C:    ok = (to_p == PH_D);
      PH_D:    ok = (to_p == PH_A) || (to_p == PH_AR);
      PH_AR:   ok = (to_p == PH_A) || (to_p == PH_C);
      default: ok = is_run(to_p);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/light_decode.sv
// light_decode
// Purely combinational lamp-code decoder.
//   code_i  [5:0] : {R1,Y1,G1,R2,Y2,G2}
//   phase_o       : matching phase, PH_ILL for any code outside the plan
module light_decode
  import traffic_pkg::*;
(
  input  logic [5:0] code_i,
  output phase_e     phase_o
);

  always_comb begin
    phase_o = PH_ILL;
    case (code_i)
      CODE_A:  phase_o = PH_A;
      CODE_B:  phase_o = PH_B;
      CODE_C:  phase_o = PH_C;
      CODE_D:  phase_o = PH_D;
      CODE_AR: phase_o = PH_AR;
      default: phase_o = PH_ILL;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Watches the lamp drives of a two-way traffic light controller, tracks
// the current phase, measures how long each phase lasted and raises
// sticky error flags for unsafe lamp combinations, illegal codes,
// out-of-plan phase changes and wrong phase lengths.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   R1,Y1,G1,R2,Y2,G2        : observed lamp drives
//   Tgreen, Tyellow [W-1:0]  : expected green / yellow lengths (cycles)
//   err_clr                  : synchronous clear of the sticky flags
//   phase [2:0]              : current decoded phase (the monitor state)
//   dur [W-1:0], dur_phase   : length and identity of last completed phase
//   dur_valid                : one-cycle pulse, dur/dur_phase just updated
//   err_conflict, err_code, err_seq, err_timing : sticky error flags
// dur_valid has no back-pressure: a consumer must capture dur/dur_phase
// in the cycle dur_valid is high; they stay stable until the next pulse.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         R1,
  input  logic         Y1,
  input  logic         G1,
  input  logic         R2,
  input  logic         Y2,
  input  logic         G2,
  input  logic [W-1:0] Tgreen,
  input  logic [W-1:0] Tyellow,
  input  logic         err_clr,
  output logic [2:0]   phase,
  output logic [W-1:0] dur,
  output logic [2:0]   dur_phase,
  output logic         dur_valid,
  output logic         err_conflict,
  output logic         err_code,
  output logic         err_seq,
  output logic         err_timing
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  phase_e         dec_phase;
  phase_e         phase_q, phase_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   dur_q, dur_d;
  phase_e         dur_phase_q, dur_phase_d;
  logic           dur_valid_q, dur_valid_d;
  logic           err_conflict_q, err_conflict_d;
  logic           err_code_q, err_code_d;
  logic           err_seq_q, err_seq_d;
  logic           err_timing_q, err_timing_d;
  logic           conflict_hit, code_hit, seq_hit, timing_hit;

  light_decode u_decode (
    .code_i  ({R1, Y1, G1, R2, Y2, G2}),
    .phase_o (dec_phase)
  );

  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    dur_d       = dur_q;
    dur_phase_d = dur_phase_q;
    dur_valid_d = 1'b0;
    code_hit    = 1'b0;
    seq_hit     = 1'b0;
    timing_hit  = 1'b0;
    // Unsafe lamp combination is judged on every sample, phase change or not.
    conflict_hit = (!R1 && !R2) || (G1 && G2);

    if (dec_phase == phase_q) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else begin
      phase_d = dec_phase;
      cnt_d   = CNT_ONE;
      // Only running phases produce a duration report; IDLE and ILL do not.
      if (is_run(phase_q)) begin
        dur_d       = cnt_q;
        dur_phase_d = phase_q;
        dur_valid_d = 1'b1;
        case (phase_q)
          PH_A, PH_C: timing_hit = (cnt_q != Tgreen);
          PH_B, PH_D: timing_hit = (cnt_q != Tyellow);
          default:    timing_hit = 1'b0;
        endcase
        seq_hit = is_run(dec_phase) && !legal_succ(phase_q, dec_phase);
      end
      code_hit = (dec_phase == PH_ILL);
    end

    // A fresh error on the clearing edge keeps the flag set.
    err_conflict_d = (err_conflict_q && !err_clr) || conflict_hit;
    err_code_d     = (err_code_q     && !err_clr) || code_hit;
    err_seq_d      = (err_seq_q      && !err_clr) || seq_hit;
    err_timing_d   = (err_timing_q   && !err_clr) || timing_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= PH_IDLE;
      cnt_q          <= '0;
      dur_q          <= '0;
      dur_phase_q    <= PH_IDLE;
      dur_valid_q    <= 1'b0;
      err_conflict_q <= 1'b0;
      err_code_q     <= 1'b0;
      err_seq_q      <= 1'b0;
      err_timing_q   <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      dur_q          <= dur_d;
      dur_phase_q    <= dur_phase_d;
      dur_valid_q    <= dur_valid_d;
      err_conflict_q <= err_conflict_d;
      err_code_q     <= err_code_d;
      err_seq_q      <= err_seq_d;
      err_timing_q   <= err_timing_d;
    end
  end

  assign phase        = phase_q;
  assign dur          = dur_q;
  assign dur_phase    = dur_phase_q;
  assign dur_valid    = dur_valid_q;
  assign err_conflict = err_conflict_q;
  assign err_code     = err_code_q;
  assign err_seq      = err_seq_q;
  assign err_timing   = err_timing_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam int W        = 8;
  localparam int MAXC     = (1 << W) - 1;
  localparam int T_GREEN  = 10;
  localparam int T_YELLOW = 3;

  localparam logic [5:0] C_A  = 6'b001100;
  localparam logic [5:0] C_B  = 6'b010100;
  localparam logic [5:0] C_C  = 6'b100001;
  localparam logic [5:0] C_D  = 6'b100010;
  localparam logic [5:0] C_AR = 6'b100100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [5:0]   code;
  logic         R1, Y1, G1, R2, Y2, G2;
  logic [W-1:0] Tgreen, Tyellow;
  logic         err_clr;
  logic [2:0]   phase;
  logic [W-1:0] dur;
  logic [2:0]   dur_phase;
  logic         dur_valid;
  logic         err_conflict, err_code, err_seq, err_timing;

  assign {R1, Y1, G1, R2, Y2, G2} = code;

  traffic_light_monitor #(.W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .R1           (R1),
    .Y1           (Y1),
    .G1           (G1),
    .R2           (R2),
    .Y2           (Y2),
    .G2           (G2),
    .Tgreen       (Tgreen),
    .Tyellow      (Tyellow),
    .err_clr      (err_clr),
    .phase        (phase),
    .dur          (dur),
    .dur_phase    (dur_phase),
    .dur_valid    (dur_valid),
    .err_conflict (err_conflict),
    .err_code     (err_code),
    .err_seq      (err_seq),
    .err_timing   (err_timing)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Reference state: phase as an integer id, run length as an unbounded int.
  int m_phase, m_len, m_dur, m_dur_phase;
  bit m_dv, m_conf, m_code, m_seq, m_tim;
  bit legal [0:7][0:7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_decode(input logic [5:0] c);
    if (c == C_A)  return 1;
    if (c == C_B)  return 2;
    if (c == C_C)  return 3;
    if (c == C_D)  return 4;
    if (c == C_AR) return 5;
    return 7;
  endfunction

  task automatic build_plan();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        legal[i][j] = 1'b0;
    legal[1][2] = 1; legal[2][3] = 1; legal[2][5] = 1; legal[3][4] = 1;
    legal[4][1] = 1; legal[4][5] = 1; legal[5][1] = 1; legal[5][3] = 1;
    for (int j = 1; j <= 5; j++) begin
      legal[0][j] = 1;
      legal[7][j] = 1;
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_dur = 0; m_dur_phase = 0;
    m_dv = 0; m_conf = 0; m_code = 0; m_seq = 0; m_tim = 0;
  endtask

  task automatic model_edge(input logic [5:0] c, input logic clr);
    int np;
    bit nconf, ncode, nseq, ntim;
    np    = m_decode(c);
    nconf = (!c[5] && !c[2]) || (c[3] && c[0]);
    ncode = 0; nseq = 0; ntim = 0;
    m_dv  = 0;
    if (np == m_phase) begin
      m_len++;
    end else begin
      if (m_phase >= 1 && m_phase <= 5) begin
        m_dur       = (m_len > MAXC) ? MAXC : m_len;
        m_dur_phase = m_phase;
        m_dv        = 1;
        if ((m_phase == 1 || m_phase == 3) && m_dur != T_GREEN)  ntim = 1;
        if ((m_phase == 2 || m_phase == 4) && m_dur != T_YELLOW) ntim = 1;
        if (np >= 1 && np <= 5 && !legal[m_phase][np]) nseq = 1;
      end
      if (np == 7) ncode = 1;
      m_phase = np;
      m_len   = 1;
    end
    m_conf = (m_conf && !clr) || nconf;
    m_code = (m_code && !clr) || ncode;
    m_seq  = (m_seq  && !clr) || nseq;
    m_tim  = (m_tim  && !clr) || ntim;
  endtask

  task automatic compare_all();
    check("phase",        phase,        m_phase);
    check("dur_valid",    dur_valid,    m_dv);
    check("dur",          dur,          m_dur);
    check("dur_phase",    dur_phase,    m_dur_phase);
    check("err_conflict", err_conflict, m_conf);
    check("err_code",     err_code,     m_code);
    check("err_seq",      err_seq,      m_seq);
    check("err_timing",   err_timing,   m_tim);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [5:0] c, input logic clr);
    code    = c;
    err_clr = clr;
    @(posedge clk);
    if (rst_n) model_edge(c, clr);
    #1;
    compare_all();
  endtask

  task automatic run(input logic [5:0] c, input int n);
    for (int i = 0; i < n; i++) step(c, 1'b0);
  endtask

  task automatic do_reset(input logic [5:0] c);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    step(c, 1'b0);
    step(c, 1'b0);
    #3 rst_n = 1'b1;
  endtask

  function automatic logic [5:0] succ_code(input logic [5:0] c);
    if (c == C_A) return C_B;
    if (c == C_B) return C_C;
    if (c == C_C) return C_D;
    if (c == C_D) return C_A;
    return C_A;
  endfunction

  logic [5:0] legal_codes [0:4];

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] cur, nxt;
    int len;
    build_plan();
    legal_codes[0] = C_A; legal_codes[1] = C_B; legal_codes[2] = C_C;
    legal_codes[3] = C_D; legal_codes[4] = C_AR;
    Tgreen  = W'(T_GREEN);
    Tyellow = W'(T_YELLOW);
    code    = 6'b000000;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    #1;
    model_reset();
    compare_all();
    step(C_AR, 1'b0);
    #3 rst_n = 1'b1;

    // Nominal cycle with correct timings.
    run(C_A, 10);
    step(C_B, 1'b0);
    check("nom_dur_A", dur, T_GREEN);
    check("nom_dv_A", dur_valid, 1);
    run(C_B, 2);
    run(C_C, 10);
    run(C_D, 3);
    step(C_A, 1'b0);
    check("nom_dur_D", dur, T_YELLOW);
    check("nom_dphase_D", dur_phase, 4);
    check("nom_noerr", {err_conflict, err_code, err_seq, err_timing}, 0);

    // Long green: A lasts 12 cycles, then clear the timing flag.
    run(C_A, 11);
    step(C_B, 1'b0);
    check("long_dur_A", dur, 12);
    check("long_timing", err_timing, 1);
    step(C_B, 1'b1);
    check("long_cleared", err_timing, 0);
    step(C_B, 1'b0);
    run(C_C, 10);
    run(C_D, 3);

    // Out-of-plan change A -> C.
    run(C_A, 5);
    step(C_C, 1'b0);
    check("seq_flag", err_seq, 1);
    check("seq_dur", dur, 5);
    check("seq_dphase", dur_phase, 1);
    step(C_C, 1'b1);

    // Both greens for one cycle, then back to A.
    step(6'b001001, 1'b0);
    check("conf_flag", err_conflict, 1);
    check("conf_code", err_code, 1);
    check("conf_phase", phase, 7);
    step(C_A, 1'b0);
    check("ill_exit_dv", dur_valid, 0);
    step(C_A, 1'b1);

    // Saturation: A held 300 cycles.
    run(C_A, 298);
    step(C_B, 1'b0);
    check("sat_dur", dur, MAXC);
    run(C_B, 2);

    // Reset mid-C, release into D.
    run(C_C, 4);
    do_reset(C_C);
    step(C_D, 1'b0);
    check("rst_seq", err_seq, 0);
    check("rst_dv", dur_valid, 0);
    check("rst_phase", phase, 4);
    run(C_D, 2);

    // Randomized segments.
    cur = C_D;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        nxt = 6'($urandom_range(0, 63));
        len = $urandom_range(1, 3);
      end else begin
        if ($urandom_range(0, 3) != 0) nxt = succ_code(cur);
        else nxt = legal_codes[$urandom_range(0, 4)];
        if ((nxt == C_A || nxt == C_C) && $urandom_range(0, 1) == 1) len = T_GREEN;
        else if ((nxt == C_B || nxt == C_D) && $urandom_range(0, 1) == 1) len = T_YELLOW;
        else len = $urandom_range(1, 14);
      end
      for (int i = 0; i < len; i++)
        step(nxt, ($urandom_range(0, 7) == 0));
      cur = nxt;
      if ($urandom_range(0, 59) == 0) do_reset(cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
